mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one SRAM-like memory port (req/addr_ok/data_ok handshake) between the instruction-fetch requester and the data (load/store) requester.
- Sits between the IF/MEM stages and the memory bridge.
- Tracks outstanding transactions in issue order and routes each data_ok/rdata back to the requester that issued it.
- Stalls new issues when the outstanding limit is reached.

Parameters:
OUTSTANDING, 2, max in-flight accepted-but-not-returned transactions (power of 2, >=1)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
i_req  in  1  fetch request
i_addr  in  ADDR_W  fetch address (read only; word size, no write)
i_addr_ok  out  1  fetch address accepted
i_data_ok  out  1  fetch data returned
i_rdata  out  DATA_W  fetch read data
d_req  in  1  data request
d_wr  in  1  1=store, 0=load
d_size  in  2  0=byte, 1=half, 2=word
d_wstrb  in  DATA_W/8  byte strobes
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_addr_ok  out  1  data address accepted
d_data_ok  out  1  load data returned / store done
d_rdata  out  DATA_W  load data
m_req  out  1  request to memory
m_wr  out  1  write
m_size  out  2  size
m_wstrb  out  DATA_W/8  strobes
m_addr  out  ADDR_W  address
m_wdata  out  DATA_W  write data
m_addr_ok  in  1  memory accepted address
m_data_ok  in  1  memory returns data/ack
m_rdata  in  DATA_W  memory read data

Behaviour:
- Address handshake: a transaction is accepted in the cycle where m_req & m_addr_ok.
- i_addr_ok / d_addr_ok = m_addr_ok gated by the current grant. Only the granted side sees it.
- Grant (default, macro off): d_req has fixed priority over i_req.
- Lock: once m_req is high and not accepted, the grant holds on that requester until acceptance, even if the other side raises req. Requesters hold req and payload stable until addr_ok.
- Fetch mux: m_wr=0, m_size=2, m_wstrb=0, m_wdata=0.
- Owner FIFO: depth OUTSTANDING, 1 bit per entry (0=fetch, 1=data).
  - Push on accept.
  - Pop on m_data_ok.
  - Push and pop in the same cycle are both allowed; count is unchanged.
- Full: when count==OUTSTANDING, m_req=0 and both addr_ok=0. Issue resumes the cycle after a pop (registered count).
- Return routing:
  - i_data_ok = m_data_ok & head==0.
  - d_data_ok = m_data_ok & head==1.
  - m_rdata is driven combinationally to both i_rdata and d_rdata.
- Returns are strictly in order; memory must return in order.
- m_data_ok with an empty FIFO: ignored, no data_ok raised, count stays 0.
- Latency: zero-cycle combinational pass-through on both phases; state only in the FIFO/lock/count registers.
- Reset: FIFO empty, count=0, lock cleared, rr pointer=fetch. All outputs 0 while reset is high. Reset mid-transaction drops all in-flight ownership; late m_data_ok after reset is ignored.
- Pointers wrap modulo OUTSTANDING.

Optional Feature:
ARB_RR_EN
- Defined: round-robin. A 1-bit last-grant register updates on every accept. When both req are high and no lock is held, grant goes to the side not last granted. Lock rule still applies.
- Undefined: fixed data priority as above. Fetch can starve while d_req stays high.

Test Plan:
- Single fetch: i_req=1, i_addr=0x1c000000, m_addr_ok=1 same cycle, m_data_ok 2 cycles later with m_rdata=0x02800c0c -> i_addr_ok=1 in cycle 0, i_data_ok=1 with i_rdata=0x02800c0c, d_data_ok=0, count back to 0.
- Simultaneous req (macro off): i_req=d_req=1, d_wr=1, d_addr=0x1000, d_wstrb=0xF, d_wdata=0xDEADBEEF -> first accept is data with m_wr=1, m_wdata=0xDEADBEEF; fetch accepted next cycle. Returns: data_ok then fetch data_ok, in order.
- Full stall, OUTSTANDING=2: two fetches accepted, no m_data_ok -> third cycle m_req=0, i_addr_ok=0. Assert m_data_ok -> next cycle m_req=1 again.
- Lock: d_req=1 with m_addr_ok=0 for 3 cycles while i_req toggles -> m_addr stays d_addr for all 3 cycles. Raise m_addr_ok -> d_addr_ok=1.
- Reset mid-flight: one fetch outstanding, pulse reset, then m_data_ok=1 -> i_data_ok=0, d_data_ok=0, count=0.
- ARB_RR_EN defined: i_req=d_req=1 held, m_addr_ok=1 every cycle, m_data_ok every cycle -> grants alternate data, fetch, data, fetch.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data requesters,
// tracking in-flight ownership in issue order. Define ARB_RR_EN for round-robin grant.
module mem_port_arbiter #(
  parameter int OUTSTANDING = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_wr,
  input  logic [1:0]          d_size,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_wr,
  output logic [1:0]          m_size,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_addr_ok,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_e;

  owner_e             fifo_q [OUTSTANDING];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               lock_q, lock_d;
  owner_e             lock_owner_q;
  owner_e             grant, head;
  logic               full, empty, accept, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CNT_W'(OUTSTANDING));
  assign empty = (count_q == '0);

`ifdef ARB_RR_EN
  owner_e last_q;
`endif

  always_comb begin
    // NOTE: default first so every path assigns grant and no latch is inferred.
    grant = OWN_FETCH;
    if (lock_q) begin
      grant = lock_owner_q;
    end else if (d_req && i_req) begin
`ifdef ARB_RR_EN
      grant = (last_q == OWN_DATA) ? OWN_FETCH : OWN_DATA;
`else
      grant = OWN_DATA;
`endif
    end else if (d_req) begin
      grant = OWN_DATA;
    end
  end

  assign m_req     = (i_req | d_req) & ~full & ~reset;
  assign accept    = m_req & m_addr_ok;
  assign i_addr_ok = accept & (grant == OWN_FETCH);
  assign d_addr_ok = accept & (grant == OWN_DATA);

  always_comb begin
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_wstrb = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (m_req) begin
      if (grant == OWN_DATA) begin
        m_wr    = d_wr;
        m_size  = d_size;
        m_wstrb = d_wstrb;
        m_addr  = d_addr;
        m_wdata = d_wdata;
      end else begin
        m_size  = 2'd2;
        m_addr  = i_addr;
      end
    end
  end

  // Returns with nothing outstanding are stray acks and are dropped.
  assign head      = fifo_q[rd_ptr_q];
  assign pop       = m_data_ok & ~empty & ~reset;
  assign i_data_ok = pop & (head == OWN_FETCH);
  assign d_data_ok = pop & (head == OWN_DATA);
  assign i_rdata   = reset ? '0 : m_rdata;
  assign d_rdata   = reset ? '0 : m_rdata;

  always_comb begin
    wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(accept) - CNT_W'(pop);
    // A presented-but-unaccepted request pins the grant for the next cycle.
    lock_d   = m_req & ~m_addr_ok;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      lock_q       <= 1'b0;
      lock_owner_q <= OWN_FETCH;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      lock_q       <= lock_d;
      lock_owner_q <= grant;
    end
  end

  // NOTE: owner storage is not reset; entries are only read while count_q marks them valid.
  always_ff @(posedge clk) begin
    if (accept) fifo_q[wr_ptr_q] <= grant;
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset)       last_q <= OWN_FETCH;
    else if (accept) last_q <= grant;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (OUTSTANDING=2); covers
// fixed-priority or round-robin grant depending on ARB_RR_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_addr_ok, i_data_ok;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_wr, d_addr_ok, d_data_ok;
  logic [1:0]  d_size;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  mem_port_arbiter #(.OUTSTANDING(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after posedge; outputs are sampled at the following negedge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = '0;
    d_req = 0; d_wr = 0; d_size = 2'd2; d_wstrb = '0; d_addr = '0; d_wdata = '0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset = 1;
    next();
    reset = 0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1;
    // Outputs must stay low during reset even with live requests.
    i_req = 1; i_addr = 32'h1c00_0000; m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h1234;
    next();
    sample();
    check("rst_m_req", m_req, 0);
    check("rst_i_addr_ok", i_addr_ok, 0);
    check("rst_i_data_ok", i_data_ok, 0);
    check("rst_i_rdata", i_rdata, 0);
    next();
    idle_inputs();
    reset = 0;

    // Single fetch with two-cycle return.
    i_req = 1; i_addr = 32'h1c00_0000; m_addr_ok = 1;
    sample();
    check("f1_m_req", m_req, 1);
    check("f1_m_addr", m_addr, 32'h1c00_0000);
    check("f1_i_addr_ok", i_addr_ok, 1);
    check("f1_d_addr_ok", d_addr_ok, 0);
    check("f1_fetch_fmt", {m_wr, m_size, m_wstrb, m_wdata}, {1'b0, 2'd2, 4'h0, 32'h0});
    next();
    i_req = 0; m_addr_ok = 0;
    next();
    m_data_ok = 1; m_rdata = 32'h0280_0c0c;
    sample();
    check("f1_i_data_ok", i_data_ok, 1);
    check("f1_i_rdata", i_rdata, 32'h0280_0c0c);
    check("f1_d_data_ok", d_data_ok, 0);
    next();
    sample();
    check("f1_stray_i_ok", i_data_ok, 0);
    check("f1_stray_d_ok", d_data_ok, 0);
    next();
    m_data_ok = 0;

    // Simultaneous requests: store goes first under fixed priority and from reset in round-robin.
    i_req = 1; i_addr = 32'h1c00_0004;
    d_req = 1; d_wr = 1; d_addr = 32'h1000; d_wstrb = 4'hF; d_wdata = 32'hDEAD_BEEF; d_size = 2'd2;
    m_addr_ok = 1;
    sample();
    check("sim_d_addr_ok", {d_addr_ok, i_addr_ok}, 2'b10);
    check("sim_store", {m_wr, m_addr, m_wstrb, m_wdata}, {1'b1, 32'h1000, 4'hF, 32'hDEAD_BEEF});
    next();
    d_req = 0;
    sample();
    check("sim_i_addr_ok", {d_addr_ok, i_addr_ok}, 2'b01);
    check("sim_fetch", {m_wr, m_addr, m_wdata}, {1'b0, 32'h1c00_0004, 32'h0});
    next();
    i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h55;
    sample();
    check("sim_ret0", {d_data_ok, i_data_ok}, 2'b10);
    next();
    m_rdata = 32'h66;
    sample();
    check("sim_ret1", {d_data_ok, i_data_ok}, 2'b01);
    check("sim_ret1_d", i_rdata, 32'h66);
    next();
    m_data_ok = 0;

    // Full stall at two outstanding, resuming the cycle after a pop.
    i_req = 1; i_addr = 32'h2000; m_addr_ok = 1;
    sample(); check("full_acc0", i_addr_ok, 1);
    next();
    sample(); check("full_acc1", i_addr_ok, 1);
    next();
    sample();
    check("full_m_req", m_req, 0);
    check("full_i_addr_ok", i_addr_ok, 0);
    next();
    m_data_ok = 1;
    sample();
    check("full_pop_m_req", m_req, 0);
    check("full_pop_i_ok", i_data_ok, 1);
    next();
    m_data_ok = 0;
    sample();
    check("full_resume", {m_req, i_addr_ok}, 2'b11);
    next();
    i_req = 0; m_addr_ok = 0; m_data_ok = 1;
    sample(); check("full_drain0", i_data_ok, 1);
    next();
    sample(); check("full_drain1", i_data_ok, 1);
    next();
    m_data_ok = 0;

    // Fetch lock: a data request arriving later must not steal the pending grant.
    i_req = 1; i_addr = 32'h3000;
    next();
    d_req = 1; d_wr = 0; d_addr = 32'h4000; d_wstrb = 4'h0; d_wdata = '0; m_addr_ok = 1;
    sample();
    check("lockf_m_addr", m_addr, 32'h3000);
    check("lockf_ok", {d_addr_ok, i_addr_ok}, 2'b01);
    next();
    // Data lock held for three cycles while fetch toggles.
    i_req = 0; m_addr_ok = 0;
    for (int c = 0; c < 3; c++) begin
      sample();
      check($sformatf("lockd_m_addr%0d", c), m_addr, 32'h4000);
      next();
      i_req = ~i_req;
    end
    m_addr_ok = 1;
    sample();
    check("lockd_ok", {d_addr_ok, i_addr_ok}, 2'b10);
    next();
    i_req = 0; d_req = 0; m_addr_ok = 0; m_data_ok = 1;
    sample(); check("lock_ret0", {d_data_ok, i_data_ok}, 2'b01);
    next();
    sample(); check("lock_ret1", {d_data_ok, i_data_ok}, 2'b10);
    next();
    m_data_ok = 0;

    // Reset with a fetch in flight: late return is ignored and count restarts at 0.
    i_req = 1; i_addr = 32'h5000; m_addr_ok = 1;
    next();
    pulse_reset();
    m_data_ok = 1;
    sample();
    check("rstmid_ok", {d_data_ok, i_data_ok}, 2'b00);
    next();
    m_data_ok = 0; i_req = 1; i_addr = 32'h5004; m_addr_ok = 1;
    sample(); check("rstmid_acc0", i_addr_ok, 1);
    next();
    sample(); check("rstmid_acc1", i_addr_ok, 1);
    next();
    sample(); check("rstmid_full", m_req, 0);

    // Contention with continuous accept and return; the grant pattern depends on the build.
    pulse_reset();
    i_req = 1; i_addr = 32'h6000; d_req = 1; d_wr = 0; d_addr = 32'h7000;
    m_addr_ok = 1; m_data_ok = 1;
    for (int c = 0; c < 4; c++) begin
      logic [1:0] exp_grant;
`ifdef ARB_RR_EN
      exp_grant = (c % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_grant = 2'b10;
`endif
      sample();
      check($sformatf("arb_grant%0d", c), {d_addr_ok, i_addr_ok}, exp_grant);
      next();
    end
    pulse_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
